// File: rtl/cache_pkg.sv
// Shared types and helpers for the coherence-bus front end.
package cache_pkg;

    localparam int unsigned CPU_CORES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    // Index width for n ports, never narrower than one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Request/grant handshake between the L1 request ports, the arbiter and the bus FSM.
interface bus_rr_arbiter_if
    import cache_pkg::*;
#(
    parameter int unsigned NUM_REQ = CPU_CORES
) ();

    localparam int unsigned ID_W = id_w(NUM_REQ);

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ack;
    logic               gnt_valid;
    logic [ID_W-1:0]    gnt_id;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic               bus_accept;
    logic               bus_done;
    logic               busy;

    modport master (
        input  req_valid, bus_accept, bus_done,
        output req_ack, gnt_valid, gnt_id, gnt_onehot, busy
    );

    modport slave (
        output req_valid, bus_accept, bus_done,
        input  req_ack, gnt_valid, gnt_id, gnt_onehot, busy
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating first-one finder: first set bit of i_vec scanning from i_ptr upward with wrap.
module rr_pick
    import cache_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = id_w(N)
) (
    input  logic [N-1:0]  i_vec,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx_c,
    output logic          o_found_c
);

    logic [IW-1:0] w_pos;

    always_comb begin
        o_idx_c   = '0;
        o_found_c = 1'b0;
        w_pos     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = IW'((32'(i_ptr) + k) % N);
            if (!o_found_c && i_vec[w_pos]) begin
                o_found_c = 1'b1;
                o_idx_c   = w_pos;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin coherence-bus arbiter with transaction-long grant lock and age-based
// starvation escalation.
module bus_rr_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned NUM_REQ      = CPU_CORES,
    parameter int unsigned AGE_BITS     = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic              clk,
    input logic              reset_n,
    bus_rr_arbiter_if.master bif
);

    localparam int unsigned         ID_W    = id_w(NUM_REQ);
    localparam logic [AGE_BITS-1:0] AGE_MAX = '1;
    localparam logic [AGE_BITS-1:0] URGENT  = AGE_BITS'(STARVE_LIMIT);
    localparam logic [ID_W-1:0]     LAST_ID = ID_W'(NUM_REQ - 1);

    arb_state_t          r_state, w_state_nxt;
    logic [ID_W-1:0]     r_ptr, w_ptr_nxt;
    logic                r_gnt_valid, w_gnt_valid_nxt;
    logic [ID_W-1:0]     r_gnt_id, w_gnt_id_nxt;
    logic [NUM_REQ-1:0]  r_gnt_onehot, w_gnt_onehot_nxt;
    logic                r_busy;
    logic [AGE_BITS-1:0] r_age [NUM_REQ];
    logic [NUM_REQ-1:0]  w_ack_c;
    logic [NUM_REQ-1:0]  w_urgent;
    logic [NUM_REQ-1:0]  w_cand;
    logic [ID_W-1:0]     w_pick_idx;
    logic                w_pick_found;

    // Urgent requesters, if any, restrict the candidate set.
    always_comb begin
        w_urgent = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_urgent[i] = bif.req_valid[i] && (r_age[i] >= URGENT);
        end
    end

    assign w_cand = (|w_urgent) ? w_urgent : bif.req_valid;

    rr_pick #(
        .N (NUM_REQ),
        .IW(ID_W)
    ) u_pick (
        .i_vec    (w_cand),
        .i_ptr    (r_ptr),
        .o_idx_c  (w_pick_idx),
        .o_found_c(w_pick_found)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_gnt_valid_nxt  = r_gnt_valid;
        w_gnt_id_nxt     = r_gnt_id;
        w_gnt_onehot_nxt = r_gnt_onehot;
        w_ack_c          = '0;
        unique case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_gnt_valid_nxt  = 1'b1;
                    w_gnt_id_nxt     = w_pick_idx;
                    w_gnt_onehot_nxt = NUM_REQ'(1) << w_pick_idx;
                    w_state_nxt      = OFFER;
                end
            end
            OFFER: begin
                // Accept beats a same-cycle withdrawal; nothing preempts a held offer.
                if (bif.bus_accept) begin
                    w_ack_c     = r_gnt_onehot;
                    w_ptr_nxt   = (r_gnt_id == LAST_ID) ? '0 : ID_W'(r_gnt_id + ID_W'(1));
                    w_state_nxt = BUSY;
                end else if (!bif.req_valid[r_gnt_id]) begin
                    w_gnt_valid_nxt  = 1'b0;
                    w_gnt_id_nxt     = '0;
                    w_gnt_onehot_nxt = '0;
                    w_state_nxt      = IDLE;
                end
            end
            BUSY: begin
                if (bif.bus_done) begin
                    w_gnt_valid_nxt  = 1'b0;
                    w_gnt_id_nxt     = '0;
                    w_gnt_onehot_nxt = '0;
                    w_state_nxt      = IDLE;
                end
            end
            default: begin
                w_gnt_valid_nxt  = 1'b0;
                w_gnt_id_nxt     = '0;
                w_gnt_onehot_nxt = '0;
                w_state_nxt      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr        <= '0;
            r_gnt_valid  <= 1'b0;
            r_gnt_id     <= '0;
            r_gnt_onehot <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_ptr        <= w_ptr_nxt;
            r_gnt_valid  <= w_gnt_valid_nxt;
            r_gnt_id     <= w_gnt_id_nxt;
            r_gnt_onehot <= w_gnt_onehot_nxt;
            r_busy       <= (w_state_nxt == BUSY);
        end
    end

    // Wait age per port: counts cycles spent requesting without being taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!bif.req_valid[i] || w_ack_c[i]) begin
                    r_age[i] <= '0;
                end else if (r_age[i] != AGE_MAX) begin
                    r_age[i] <= r_age[i] + AGE_BITS'(1);
                end
            end
        end
    end

    assign bif.req_ack    = w_ack_c;
    assign bif.gnt_valid  = r_gnt_valid;
    assign bif.gnt_id     = r_gnt_id;
    assign bif.gnt_onehot = r_gnt_onehot;
    assign bif.busy       = r_busy;

    a_onehot_matches_id: assert property (@(posedge clk) disable iff (!reset_n)
        r_gnt_onehot == (r_gnt_valid ? (NUM_REQ'(1) << r_gnt_id) : NUM_REQ'(0)));

    a_ack_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(w_ack_c));

    a_ack_only_on_accept: assert property (@(posedge clk) disable iff (!reset_n)
        (w_ack_c != '0) |-> (r_state == OFFER && bif.bus_accept));

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_bus_rr_arbiter;

    logic clk;
    logic reset_n;

    bus_rr_arbiter_if #(.NUM_REQ(4)) bif   ();
    bus_rr_arbiter_if #(.NUM_REQ(4)) bif_s ();

    bus_rr_arbiter #(.NUM_REQ(4), .AGE_BITS(4), .STARVE_LIMIT(8)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bif    (bif)
    );

    // Second instance with a short starvation limit for the escalation case.
    bus_rr_arbiter #(.NUM_REQ(4), .AGE_BITS(4), .STARVE_LIMIT(2)) dut_s (
        .clk    (clk),
        .reset_n(reset_n),
        .bif    (bif_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       acc;
        logic       done;
        logic       gv;
        logic [1:0] id;
        logic [3:0] ack;
        logic       busy;
    } vec_t;

    vec_t tbl[$];
    int   n_err;
    int   n_chk;

    task automatic add(input logic rst, input logic [3:0] req, input logic acc, input logic done,
                       input logic gv, input logic [1:0] id, input logic [3:0] ack, input logic busy);
        vec_t v;
        v.rst = rst; v.req = req; v.acc = acc; v.done = done;
        v.gv = gv; v.id = id; v.ack = ack; v.busy = busy;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bif.req_valid = '0; bif.bus_accept = 1'b0; bif.bus_done = 1'b0;
        bif_s.req_valid = '0; bif_s.bus_accept = 1'b0; bif_s.bus_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_outs(input string tag, input logic gv, input logic [1:0] id,
                            input logic [3:0] ack, input logic busy);
        logic [3:0] oh;
        oh = gv ? (4'd1 << id) : 4'd0;
        chk({tag, " gnt_valid"}, 32'(bif.gnt_valid), 32'(gv));
        if (gv) chk({tag, " gnt_id"}, 32'(bif.gnt_id), 32'(id));
        chk({tag, " gnt_onehot"}, 32'(bif.gnt_onehot), 32'(oh));
        chk({tag, " req_ack"}, 32'(bif.req_ack), 32'(ack));
        chk({tag, " busy"}, 32'(bif.busy), 32'(busy));
    endtask

    initial begin
        int order[5];
        n_err = 0;
        n_chk = 0;
        order = '{0, 1, 2, 3, 0};

        // Single port, accept ignored in BUSY, re-grant of a lone requester.
        add(1, 4'b0001, 0, 0,  0, 2'd0, 4'b0000, 0);
        add(0, 4'b0001, 1, 0,  1, 2'd0, 4'b0001, 0);
        add(0, 4'b0000, 1, 1,  1, 2'd0, 4'b0000, 1);
        add(0, 4'b0000, 1, 1,  0, 2'd0, 4'b0000, 0);
        add(0, 4'b0001, 0, 0,  0, 2'd0, 4'b0000, 0);
        add(0, 4'b0001, 1, 0,  1, 2'd0, 4'b0001, 0);
        add(0, 4'b0000, 0, 1,  1, 2'd0, 4'b0000, 1);
        add(0, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0);
        // All four ports held: rotation 0,1,2,3,0.
        for (int t = 0; t < 5; t++) begin
            add((t == 0), 4'b1111, 0, 0,  0, 2'd0, 4'b0000, 0);
            add(0, 4'b1111, 1, 0,  1, 2'(order[t]), 4'(1 << order[t]), 0);
            add(0, 4'b1111, 0, 1,  1, 2'(order[t]), 4'b0000, 1);
        end
        // ptr=3 scan, done ignored in OFFER, accept beats withdrawal, pointer wrap.
        add(1, 4'b0100, 0, 0,  0, 2'd0, 4'b0000, 0);
        add(0, 4'b0100, 1, 0,  1, 2'd2, 4'b0100, 0);
        add(0, 4'b0000, 0, 1,  1, 2'd2, 4'b0000, 1);
        add(0, 4'b0110, 0, 0,  0, 2'd0, 4'b0000, 0);
        add(0, 4'b0110, 0, 1,  1, 2'd1, 4'b0000, 0);
        add(0, 4'b0110, 1, 0,  1, 2'd1, 4'b0010, 0);
        add(0, 4'b0110, 0, 1,  1, 2'd1, 4'b0000, 1);
        add(0, 4'b0110, 0, 0,  0, 2'd0, 4'b0000, 0);
        add(0, 4'b0010, 1, 0,  1, 2'd2, 4'b0100, 0);
        add(0, 4'b0010, 0, 1,  1, 2'd2, 4'b0000, 1);
        add(0, 4'b0010, 0, 0,  0, 2'd0, 4'b0000, 0);
        add(0, 4'b0010, 0, 0,  1, 2'd1, 4'b0000, 0);
        add(0, 4'b0000, 0, 0,  1, 2'd1, 4'b0000, 0);
        add(0, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0);

        // Reset state, checked while reset is held and just after release.
        reset_n = 1'b0;
        bif.req_valid = '0; bif.bus_accept = 1'b0; bif.bus_done = 1'b0;
        bif_s.req_valid = '0; bif_s.bus_accept = 1'b0; bif_s.bus_done = 1'b0;
        #2;
        chk_outs("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        chk("reset gnt_id", 32'(bif.gnt_id), 32'd0);
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            bif.req_valid  = tbl[i].req;
            bif.bus_accept = tbl[i].acc;
            bif.bus_done   = tbl[i].done;
            #1;
            chk_outs($sformatf("row%0d", i), tbl[i].gv, tbl[i].id, tbl[i].ack, tbl[i].busy);
            tick();
        end

        // Withdrawal in OFFER: grant dropped, no ack, age cleared.
        do_reset();
        bif.req_valid = 4'b0100;
        tick();
        #1;
        chk_outs("wd offer", 1'b1, 2'd2, 4'b0000, 1'b0);
        bif.req_valid = 4'b0000;
        #1;
        chk("wd ack", 32'(bif.req_ack), 32'd0);
        tick();
        chk_outs("wd idle", 1'b0, 2'd0, 4'b0000, 1'b0);
        chk("wd age2", 32'(dut.r_age[2]), 32'd0);
        tick();
        chk("wd stay", 32'(bif.gnt_valid), 32'd0);

        // Starvation escalation on the STARVE_LIMIT=2 instance.
        do_reset();
        bif_s.req_valid = 4'b1011;
        tick();
        bif_s.bus_accept = 1'b1;
        #1;
        chk("st g0 id", 32'(bif_s.gnt_id), 32'd0);
        chk("st g0 ack", 32'(bif_s.req_ack), 32'b0001);
        tick();
        bif_s.bus_accept = 1'b0;
        bif_s.bus_done = 1'b1;
        tick();
        bif_s.bus_done = 1'b0;
        #1;
        chk("st idle gv", 32'(bif_s.gnt_valid), 32'd0);
        tick();
        bif_s.bus_accept = 1'b1;
        #1;
        chk("st g1 id", 32'(bif_s.gnt_id), 32'd1);
        chk("st g1 ack", 32'(bif_s.req_ack), 32'b0010);
        tick();
        bif_s.bus_accept = 1'b0;
        bif_s.bus_done = 1'b1;
        bif_s.req_valid = 4'b1111;
        tick();
        bif_s.bus_done = 1'b0;
        tick();
        bif_s.bus_accept = 1'b1;
        #1;
        chk("st g2 gv", 32'(bif_s.gnt_valid), 32'd1);
        chk("st g2 id", 32'(bif_s.gnt_id), 32'd3);
        chk("st g2 onehot", 32'(bif_s.gnt_onehot), 32'b1000);
        chk("st g2 ack", 32'(bif_s.req_ack), 32'b1000);
        tick();
        bif_s.bus_accept = 1'b0;
        #1;
        chk("st g2 busy", 32'(bif_s.busy), 32'd1);
        bif_s.req_valid = 4'b0000;
        bif_s.bus_done = 1'b1;
        tick();
        bif_s.bus_done = 1'b0;

        // Asynchronous reset during BUSY, then first grant scans from port 0.
        do_reset();
        bif.req_valid = 4'b0010;
        tick();
        bif.bus_accept = 1'b1;
        #1;
        chk_outs("ar offer", 1'b1, 2'd1, 4'b0010, 1'b0);
        tick();
        bif.bus_accept = 1'b0;
        bif.req_valid = 4'b1010;
        #1;
        chk_outs("ar busy", 1'b1, 2'd1, 4'b0000, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_outs("ar async", 1'b0, 2'd0, 4'b0000, 1'b0);
        chk("ar async id", 32'(bif.gnt_id), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        chk_outs("ar regrant", 1'b1, 2'd1, 4'b0000, 1'b0);
        bif.req_valid = 4'b0000;
        tick();
        chk_outs("ar end", 1'b0, 2'd0, 4'b0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
